// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared types.
// FSM encoding and selector width helper.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK,
        ST_DRIVE
    } irq_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i8080.vh
// Shared i8080 bus definitions.
// Status-byte bit positions and opcode helpers.
`ifndef I8080_VH
`define I8080_VH

`define STATUS_INTA 0

`define I8080_RST(n) (8'hC7 | (8'(n) << 3))

`endif

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-set-index priority encoder.
// valid flags any request present.
module prio_enc #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// i8080 interrupt scheduler: latches request edges,
// raises iint and supplies an RST opcode during INTA.
`include "i8080.vh"

module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int XLEN     = 8,
    parameter int NUM_IRQ  = 2,
    parameter int VEC_BASE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               inte,
    input  logic               sync,
    input  logic               dbin,
    input  logic [XLEN-1:0]    data_in,
    output logic               iint,
    output logic [XLEN-1:0]    data_out,
    output logic               data_oe,
    output logic [NUM_IRQ-1:0] pending,
    output logic               busy
);

    localparam int SW = sel_width(NUM_IRQ);

    generate
        if (VEC_BASE < 0 || VEC_BASE + NUM_IRQ > 8) begin : g_chk
            $error("irq_ctrl: VEC_BASE+NUM_IRQ must not exceed 8");
        end
    endgenerate

    irq_state_t         state;
    irq_state_t         state_nxt;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [SW-1:0]      enc_idx;
    logic [SW-1:0]      sel_q;
    logic               enc_vld;
    logic               ack_take;
    logic               clr;
    logic               in_inta;
    logic               unused_bits;

    assign unused_bits = ^data_in;

    prio_enc #(
        .N(NUM_IRQ),
        .W(SW)
    ) u_prio (
        .req  (pending),
        .idx  (enc_idx),
        .valid(enc_vld)
    );

    assign irq_rise = irq & ~irq_q;

    always_comb begin
        state_nxt = state;
        ack_take  = 1'b0;
        clr       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enc_vld && inte) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (sync && data_in[`STATUS_INTA]) begin
                    state_nxt = ST_ACK;
                    ack_take  = 1'b1;
                end else if (!inte) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (dbin) state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (!dbin) begin
                    state_nxt = ST_IDLE;
                    clr       = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_mask[i] = clr && (sel_q == SW'(i));
        end
    end

    // A fresh edge in the clearing cycle re-sets the bit (set wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            irq_q   <= '0;
            pending <= '0;
            sel_q   <= '0;
        end else begin
            state   <= state_nxt;
            irq_q   <= irq;
            pending <= (pending & ~clr_mask) | irq_rise;
            if (ack_take) sel_q <= enc_idx;
        end
    end

    assign in_inta  = (state == ST_ACK) || (state == ST_DRIVE);
    assign data_oe  = in_inta && dbin;
    assign data_out = data_oe
                    ? XLEN'(`I8080_RST(VEC_BASE + int'(sel_q)))
                    : '0;
    assign iint     = (state == ST_REQ);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl.
// Cycle vector table plus reset corner sequence.
module tb_irq_ctrl;

    typedef struct packed {
        logic [1:0] irq;
        logic       inte;
        logic       sync;
        logic [7:0] st;
        logic       dbin;
        logic       iint;
        logic       oe;
        logic [7:0] dout;
        logic [1:0] pend;
        logic       busy;
    } vec_t;

    typedef struct packed {
        logic       iint;
        logic       oe;
        logic [7:0] dout;
        logic [1:0] pend;
        logic       busy;
    } exp_t;

    localparam logic [7:0] S_INTA = 8'h23;
    localparam logic [7:0] S_MEMR = 8'h82;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] irq = '0;
    logic       inte = 1'b0;
    logic       sync = 1'b0;
    logic       dbin = 1'b0;
    logic [7:0] data_in = '0;
    logic       iint;
    logic [7:0] data_out;
    logic       data_oe;
    logic [1:0] pending;
    logic       busy;

    int total = 0;
    int bad = 0;

    vec_t vecs[$];
    exp_t exp_q[$];

    irq_ctrl #(
        .XLEN(8),
        .NUM_IRQ(2),
        .VEC_BASE(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .inte    (inte),
        .sync    (sync),
        .dbin    (dbin),
        .data_in (data_in),
        .iint    (iint),
        .data_out(data_out),
        .data_oe (data_oe),
        .pending (pending),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic [1:0] i, input logic e, input logic s,
        input logic [7:0] st, input logic d, input logic ii,
        input logic oe, input logic [7:0] dout,
        input logic [1:0] p, input logic b);
        vec_t v;
        v = '{i, e, s, st, d, ii, oe, dout, p, b};
        return v;
    endfunction

    task automatic cmp(input string nm, input int row,
                       input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s row %0d: got %0h want %0h", nm, row, a, e);
        end
    endtask

    task automatic check_pop(input int row);
        exp_t e;
        if (exp_q.size() == 0) begin
            cmp("scoreboard_empty", row, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        cmp("iint", row, 32'(iint), 32'(e.iint));
        cmp("data_oe", row, 32'(data_oe), 32'(e.oe));
        cmp("data_out", row, 32'(data_out), 32'(e.dout));
        cmp("pending", row, 32'(pending), 32'(e.pend));
        cmp("busy", row, 32'(busy), 32'(e.busy));
    endtask

    task automatic step(input vec_t v, input int row);
        @(negedge clk);
        irq     = v.irq;
        inte    = v.inte;
        sync    = v.sync;
        data_in = v.sync ? v.st : 8'h00;
        dbin    = v.dbin;
        exp_q.push_back('{v.iint, v.oe, v.dout, v.pend, v.busy});
        @(posedge clk);
        #1;
        check_pop(row);
    endtask

    initial begin
        // irq inte sync st dbin | iint oe dout pend busy
        // 1: single request on line 1
        vecs.push_back(mk(2'b00,1,0,0,0, 0,0,8'h00,2'b00,0));
        vecs.push_back(mk(2'b10,1,0,0,0, 0,0,8'h00,2'b10,0));
        vecs.push_back(mk(2'b10,1,0,0,0, 1,0,8'h00,2'b10,1));
        vecs.push_back(mk(2'b10,1,1,S_INTA,0, 0,0,8'h00,2'b10,1));
        vecs.push_back(mk(2'b10,1,0,0,1, 0,1,8'hD7,2'b10,1));
        vecs.push_back(mk(2'b10,1,0,0,0, 0,0,8'h00,2'b00,0));
        // 2: simultaneous requests, lowest index first
        vecs.push_back(mk(2'b00,1,0,0,0, 0,0,8'h00,2'b00,0));
        vecs.push_back(mk(2'b11,1,0,0,0, 0,0,8'h00,2'b11,0));
        vecs.push_back(mk(2'b11,1,0,0,0, 1,0,8'h00,2'b11,1));
        vecs.push_back(mk(2'b11,1,1,S_INTA,0, 0,0,8'h00,2'b11,1));
        vecs.push_back(mk(2'b11,1,0,0,1, 0,1,8'hCF,2'b11,1));
        vecs.push_back(mk(2'b11,1,0,0,0, 0,0,8'h00,2'b10,0));
        vecs.push_back(mk(2'b11,1,0,0,0, 1,0,8'h00,2'b10,1));
        vecs.push_back(mk(2'b11,1,1,S_INTA,0, 0,0,8'h00,2'b10,1));
        vecs.push_back(mk(2'b11,1,0,0,1, 0,1,8'hD7,2'b10,1));
        vecs.push_back(mk(2'b11,1,0,0,0, 0,0,8'h00,2'b00,0));
        // 3: interrupts disabled, then enabled
        vecs.push_back(mk(2'b00,0,0,0,0, 0,0,8'h00,2'b00,0));
        vecs.push_back(mk(2'b01,0,0,0,0, 0,0,8'h00,2'b01,0));
        vecs.push_back(mk(2'b01,0,0,0,0, 0,0,8'h00,2'b01,0));
        vecs.push_back(mk(2'b01,1,0,0,0, 1,0,8'h00,2'b01,1));
        vecs.push_back(mk(2'b01,1,1,S_INTA,0, 0,0,8'h00,2'b01,1));
        vecs.push_back(mk(2'b01,1,0,0,1, 0,1,8'hCF,2'b01,1));
        vecs.push_back(mk(2'b01,1,0,0,0, 0,0,8'h00,2'b00,0));
        // 4: new edge in the clearing cycle, then inte drop in REQ
        vecs.push_back(mk(2'b00,1,0,0,0, 0,0,8'h00,2'b00,0));
        vecs.push_back(mk(2'b01,1,0,0,0, 0,0,8'h00,2'b01,0));
        vecs.push_back(mk(2'b01,1,0,0,0, 1,0,8'h00,2'b01,1));
        vecs.push_back(mk(2'b01,1,1,S_INTA,0, 0,0,8'h00,2'b01,1));
        vecs.push_back(mk(2'b00,1,0,0,1, 0,1,8'hCF,2'b01,1));
        vecs.push_back(mk(2'b01,1,0,0,0, 0,0,8'h00,2'b01,0));
        vecs.push_back(mk(2'b01,1,0,0,0, 1,0,8'h00,2'b01,1));
        vecs.push_back(mk(2'b01,0,0,0,0, 0,0,8'h00,2'b01,0));
        vecs.push_back(mk(2'b01,0,0,0,0, 0,0,8'h00,2'b01,0));
        vecs.push_back(mk(2'b01,1,0,0,0, 1,0,8'h00,2'b01,1));
        // 6: non-INTA status and read strobe in REQ
        vecs.push_back(mk(2'b01,1,1,S_MEMR,0, 1,0,8'h00,2'b01,1));
        vecs.push_back(mk(2'b01,1,0,0,1, 1,0,8'h00,2'b01,1));
        vecs.push_back(mk(2'b01,1,1,S_INTA,0, 0,0,8'h00,2'b01,1));
        vecs.push_back(mk(2'b01,1,0,0,1, 0,1,8'hCF,2'b01,1));
        vecs.push_back(mk(2'b01,1,0,0,0, 0,0,8'h00,2'b00,0));
        // lead-in to reset during DRIVE
        vecs.push_back(mk(2'b00,1,0,0,0, 0,0,8'h00,2'b00,0));
        vecs.push_back(mk(2'b10,1,0,0,0, 0,0,8'h00,2'b10,0));
        vecs.push_back(mk(2'b10,1,0,0,0, 1,0,8'h00,2'b10,1));
        vecs.push_back(mk(2'b10,1,1,S_INTA,0, 0,0,8'h00,2'b10,1));
        vecs.push_back(mk(2'b10,1,0,0,1, 0,1,8'hD7,2'b10,1));

        #12;
        exp_q.push_back('{1'b0, 1'b0, 8'h00, 2'b00, 1'b0});
        check_pop(-1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // 5: reset while driving the bus
        @(negedge clk);
        irq = 2'b11;
        #2;
        cmp("oe_before_rst", 100, 32'(data_oe), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.push_back('{1'b0, 1'b0, 8'h00, 2'b00, 1'b0});
        check_pop(101);
        @(negedge clk);
        rst  = 1'b0;
        dbin = 1'b0;
        exp_q.push_back('{1'b0, 1'b0, 8'h00, 2'b11, 1'b0});
        @(posedge clk);
        #1;
        check_pop(102);
        exp_q.push_back('{1'b1, 1'b0, 8'h00, 2'b11, 1'b1});
        @(posedge clk);
        #1;
        check_pop(103);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
